// File: rtl/rv32i_writeback.sv
// RV32I writeback stage: commits ALU results and load data into the 32x32 register file.
// Optional macro WB_INSTRET_EN adds a 64-bit retired-instruction counter output o_instret.
`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif

module rv32i_writeback #(
   parameter int unsigned LOAD_TIMEOUT = 255
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_ce,
   input  logic                        i_stall,
   input  logic                        i_flush,
   input  logic                        i_wr_rd,
   input  logic                        i_rd_valid,
   input  logic [4:0]                  i_rd_addr,
   input  logic [31:0]                 i_rd,
   input  logic [`EXCEPTION_WIDTH-1:0] i_exception,
   input  logic                        i_is_load,
   input  logic [2:0]                  i_funct3,
   input  logic [1:0]                  i_addr_lsb,
   input  logic                        i_mem_ack,
   input  logic [31:0]                 i_mem_rdata,
   input  logic [4:0]                  i_rs1_addr,
   input  logic [4:0]                  i_rs2_addr,
   output logic [31:0]                 o_rs1_data,
   output logic [31:0]                 o_rs2_data,
   output logic                        o_stall_from_wb,
   output logic                        o_retire,
   output logic                        o_load_err
`ifdef WB_INSTRET_EN
   ,
   output logic [63:0]                 o_instret
`endif
);

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOAD_TIMEOUT - 1);

   typedef enum logic [0:0] {IDLE, WAIT_LOAD} state_t;

   state_t           state;
   logic [CNT_W-1:0] tmo_cnt;
   logic [4:0]       ld_rd;
   logic [2:0]       ld_funct3;
   logic [1:0]       ld_lsb;
   logic [31:0]      regs [32];

   logic             accept_c;
   logic             wr_en_c;
   logic [4:0]       wr_addr_c;
   logic [31:0]      wr_data_c;
   logic [7:0]       ld_byte_c;
   logic [15:0]      ld_half_c;
   logic [31:0]      ld_data_c;

   assign accept_c = (state == IDLE) & i_ce & ~i_stall & ~i_flush
                     & (i_exception == `EXCEPTION_WIDTH'(0));
   assign o_stall_from_wb = (state == WAIT_LOAD);

   // Load data alignment and sign/zero extension
   always_comb begin
      ld_byte_c = i_mem_rdata[7:0];
      case (ld_lsb)
         2'd1:    ld_byte_c = i_mem_rdata[15:8];
         2'd2:    ld_byte_c = i_mem_rdata[23:16];
         2'd3:    ld_byte_c = i_mem_rdata[31:24];
         default: ld_byte_c = i_mem_rdata[7:0];
      endcase
      ld_half_c = ld_lsb[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
      case (ld_funct3)
         3'b000:  ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
         3'b001:  ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
         3'b100:  ld_data_c = {24'd0, ld_byte_c};
         3'b101:  ld_data_c = {16'd0, ld_half_c};
         default: ld_data_c = i_mem_rdata;
      endcase
   end

   // Single write port shared by ALU commits and load returns
   always_comb begin
      wr_en_c   = 1'b0;
      wr_addr_c = i_rd_addr;
      wr_data_c = i_rd;
      if (accept_c && !i_is_load && i_wr_rd && i_rd_valid) begin
         wr_en_c = (i_rd_addr != 5'd0);
      end else if (state == WAIT_LOAD && i_mem_ack && !i_flush) begin
         wr_en_c   = (ld_rd != 5'd0);
         wr_addr_c = ld_rd;
         wr_data_c = ld_data_c;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wr_en_c) begin
         regs[wr_addr_c] <= wr_data_c;
      end
   end

   // Read ports with same-cycle write bypass; x0 is hardwired to zero
   always_comb begin
      o_rs1_data = regs[i_rs1_addr];
      if (i_rs1_addr == 5'd0)                          o_rs1_data = '0;
      else if (wr_en_c && (wr_addr_c == i_rs1_addr))   o_rs1_data = wr_data_c;
      o_rs2_data = regs[i_rs2_addr];
      if (i_rs2_addr == 5'd0)                          o_rs2_data = '0;
      else if (wr_en_c && (wr_addr_c == i_rs2_addr))   o_rs2_data = wr_data_c;
   end

   // Commit / load-wait state machine; flush beats ack, ack beats timeout
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= IDLE;
         tmo_cnt    <= '0;
         ld_rd      <= '0;
         ld_funct3  <= '0;
         ld_lsb     <= '0;
         o_retire   <= 1'b0;
         o_load_err <= 1'b0;
      end else begin
         o_retire   <= 1'b0;
         o_load_err <= 1'b0;
         case (state)
            IDLE: begin
               if (accept_c) begin
                  if (i_is_load) begin
                     state     <= WAIT_LOAD;
                     ld_rd     <= i_rd_addr;
                     ld_funct3 <= i_funct3;
                     ld_lsb    <= i_addr_lsb;
                     tmo_cnt   <= '0;
                  end else begin
                     o_retire <= 1'b1;
                  end
               end
            end
            WAIT_LOAD: begin
               if (i_flush) begin
                  state <= IDLE;
               end else if (i_mem_ack) begin
                  state    <= IDLE;
                  o_retire <= 1'b1;
               end else if (tmo_cnt == TMO_LAST) begin
                  state      <= IDLE;
                  o_load_err <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef WB_INSTRET_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)         o_instret <= '0;
      else if (o_retire) o_instret <= o_instret + 64'd1;
   end
`endif

endmodule

// File: tb/tb_rv32i_writeback.sv
// Directed plus randomized bench for rv32i_writeback against a behavioural register-file model.
`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif

module tb_rv32i_writeback;
   localparam int unsigned TMO = 8;
   localparam int unsigned EW  = `EXCEPTION_WIDTH;

   logic          clk = 1'b0;
   logic          rst;
   logic          ce, stall, flush, wr_rd, rd_valid, is_load, mem_ack;
   logic [4:0]    rd_addr, rs1_addr, rs2_addr;
   logic [31:0]   rd_data, mem_rdata, rs1_data, rs2_data;
   logic [EW-1:0] exception;
   logic [2:0]    funct3;
   logic [1:0]    addr_lsb;
   logic          stall_from_wb, retire, load_err;
`ifdef WB_INSTRET_EN
   logic [63:0]   instret;
`endif

   logic [31:0] mreg [32];
   logic [63:0] ret_cnt;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rv32i_writeback #(.LOAD_TIMEOUT(TMO)) dut (
      .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_stall(stall), .i_flush(flush),
      .i_wr_rd(wr_rd), .i_rd_valid(rd_valid), .i_rd_addr(rd_addr), .i_rd(rd_data),
      .i_exception(exception), .i_is_load(is_load), .i_funct3(funct3),
      .i_addr_lsb(addr_lsb), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
      .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr), .o_rs1_data(rs1_data),
      .o_rs2_data(rs2_data), .o_stall_from_wb(stall_from_wb), .o_retire(retire),
      .o_load_err(load_err)
`ifdef WB_INSTRET_EN
      , .o_instret(instret)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference load extraction written as shifts and arithmetic
   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lsb,
                                            input logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> (8 * lsb)) & 32'h0000_00FF;
      h = (w >> (16 * (lsb / 2))) & 32'h0000_FFFF;
      case (f3)
         3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
         3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'b100:  return b;
         3'b101:  return h;
         default: return w;
      endcase
   endfunction

   task automatic read_check(input logic [4:0] a1, input logic [4:0] a2);
      rs1_addr = a1;
      rs2_addr = a2;
      #1;
      chk($sformatf("rs1_x%0d", a1), rs1_data, mreg[a1]);
      chk($sformatf("rs2_x%0d", a2), rs2_data, mreg[a2]);
   endtask

   task automatic commit(input logic [4:0] rd, input logic [31:0] d, input logic wr,
                         input logic vld, input logic stl, input logic fl,
                         input logic [EW-1:0] ex);
      logic acc;
      ce = 1'b1; is_load = 1'b0; wr_rd = wr; rd_valid = vld; rd_addr = rd; rd_data = d;
      stall = stl; flush = fl; exception = ex;
      acc = !stl && !fl && (ex == '0);
      tick();
      ce = 1'b0; stall = 1'b0; flush = 1'b0; exception = '0; wr_rd = 1'b0;
      if (acc && wr && vld && rd != 5'd0) mreg[rd] = d;
      if (acc) ret_cnt++;
      chk("commit_retire", {63'd0, retire}, {63'd0, acc});
   endtask

   task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lsb,
                       input logic [31:0] w, input int dly, input logic fl);
      ce = 1'b1; is_load = 1'b1; rd_addr = rd; funct3 = f3; addr_lsb = lsb;
      wr_rd = 1'b1; rd_valid = 1'b0; rd_data = $urandom;
      tick();
      is_load = 1'b0; ce = 1'b0;
      for (int i = 0; i < dly; i++) begin
         chk("load_stall", {63'd0, stall_from_wb}, 64'd1);
         ce = 1'b1; wr_rd = 1'b1; rd_valid = 1'b1; rd_addr = 5'($urandom); rd_data = $urandom;
         if (i == dly - 1) begin
            mem_ack = 1'b1; mem_rdata = w; flush = fl;
         end
         tick();
      end
      ce = 1'b0; wr_rd = 1'b0; mem_ack = 1'b0; flush = 1'b0; mem_rdata = $urandom;
      chk("load_stall_end", {63'd0, stall_from_wb}, 64'd0);
      if (!fl) begin
         if (rd != 5'd0) mreg[rd] = ref_load(f3, lsb, w);
         ret_cnt++;
      end
      chk("load_retire", {63'd0, retire}, {63'd0, !fl});
   endtask

   initial begin
      ce = 0; stall = 0; flush = 0; wr_rd = 0; rd_valid = 0; is_load = 0; mem_ack = 0;
      rd_addr = 0; rs1_addr = 0; rs2_addr = 0; rd_data = 0; mem_rdata = 0;
      exception = '0; funct3 = 0; addr_lsb = 0;
      for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
      ret_cnt = 0;

      // Reset state
      rst = 1'b1;
      #12;
      chk("rst_stall", {63'd0, stall_from_wb}, 64'd0);
      chk("rst_retire", {63'd0, retire}, 64'd0);
      chk("rst_load_err", {63'd0, load_err}, 64'd0);
      rst = 1'b0;
      tick();
      read_check(5'd5, 5'd31);

      // Basic commit and single retire pulse
      commit(5'd5, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      read_check(5'd5, 5'd0);
      tick();
      chk("retire_one_pulse", {63'd0, retire}, 64'd0);

      // x0 write dropped, still retires
      commit(5'd0, 32'h0000_1234, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      read_check(5'd0, 5'd5);

      // Directed loads: LB and LHU with 4 stalled cycles
      load(5'd7, 3'b000, 2'd3, 32'h80FF_FFFF, 4, 1'b0);
      read_check(5'd7, 5'd7);
      chk("lb_value", {32'd0, mreg[7]}, 64'hFFFF_FF80);
      load(5'd7, 3'b101, 2'd2, 32'h80FF_FFFF, 4, 1'b0);
      read_check(5'd7, 5'd5);
      chk("lhu_value", {32'd0, mreg[7]}, 64'h0000_80FF);

      // Flush on the ack cycle wins
      load(5'd7, 3'b010, 2'd0, 32'h1357_9BDF, 3, 1'b1);
      read_check(5'd7, 5'd7);

      // Ack while idle is ignored
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      tick();
      mem_ack = 1'b0;
      chk("idle_ack_retire", {63'd0, retire}, 64'd0);
      read_check(5'd7, 5'd5);

      // Timeout after TMO stalled cycles
      ce = 1'b1; is_load = 1'b1; rd_addr = 5'd7; funct3 = 3'b010; addr_lsb = 2'd0;
      tick();
      ce = 1'b0; is_load = 1'b0;
      for (int i = 0; i < int'(TMO); i++) begin
         chk("tmo_stall", {63'd0, stall_from_wb}, 64'd1);
         chk("tmo_err_early", {63'd0, load_err}, 64'd0);
         tick();
      end
      chk("tmo_stall_end", {63'd0, stall_from_wb}, 64'd0);
      chk("tmo_err", {63'd0, load_err}, 64'd1);
      chk("tmo_retire", {63'd0, retire}, 64'd0);
      tick();
      chk("tmo_err_pulse", {63'd0, load_err}, 64'd0);
      read_check(5'd7, 5'd5);

      // Exception, stall and flush block the commit
      commit(5'd6, 32'h6666_6666, 1'b1, 1'b1, 1'b0, 1'b0, EW'(1));
      commit(5'd6, 32'h6666_6667, 1'b1, 1'b1, 1'b1, 1'b0, '0);
      commit(5'd6, 32'h6666_6668, 1'b1, 1'b1, 1'b0, 1'b1, '0);
      commit(5'd6, 32'h6666_6669, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      read_check(5'd6, 5'd6);

      // Same-cycle bypass on both read ports
      commit(5'd9, 32'h1111_1111, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      ce = 1'b1; wr_rd = 1'b1; rd_valid = 1'b1; rd_addr = 5'd9; rd_data = 32'hCAFE_F00D;
      rs1_addr = 5'd9; rs2_addr = 5'd9;
      #1;
      chk("bypass_rs1", {32'd0, rs1_data}, 64'h0000_0000_CAFE_F00D);
      chk("bypass_rs2", {32'd0, rs2_data}, 64'h0000_0000_CAFE_F00D);
      tick();
      ce = 1'b0; wr_rd = 1'b0;
      mreg[9] = 32'hCAFE_F00D;
      ret_cnt++;
      chk("bypass_retire", {63'd0, retire}, 64'd1);
      read_check(5'd9, 5'd5);

      // Reset in the middle of a load aborts it and clears everything
      ce = 1'b1; is_load = 1'b1; rd_addr = 5'd5; funct3 = 3'b010;
      tick();
      ce = 1'b0; is_load = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("rst_mid_stall", {63'd0, stall_from_wb}, 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
      ret_cnt = 0;
      mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
      tick();
      mem_ack = 1'b0;
      chk("rst_mid_retire", {63'd0, retire}, 64'd0);
      read_check(5'd5, 5'd9);

      // Three commits then counter check
      commit(5'd1, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      commit(5'd2, 32'h0000_0002, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      commit(5'd3, 32'h0000_0003, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      tick();
      tick();
`ifdef WB_INSTRET_EN
      chk("instret_3", instret, 64'd3);
`endif

      // Randomized mix of commits and loads
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            load(5'($urandom), 3'($urandom), 2'($urandom), $urandom,
                 int'($urandom_range(1, TMO)), ($urandom_range(0, 5) == 0));
         end else begin
            commit(5'($urandom), $urandom, 1'($urandom), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 5) == 0) ? EW'($urandom_range(1, 3)) : '0);
         end
         read_check(5'($urandom), 5'($urandom));
      end
      tick();
      tick();
`ifdef WB_INSTRET_EN
      chk("instret_final", instret, ret_cnt);
`endif
      for (int i = 0; i < 32; i += 2) read_check(5'(i), 5'(i + 1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
